// File: rtl/group_collect_pkg.sv
// Shared definitions for group_collect: lane width derivation and FSM state encoding.
package group_collect_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    function automatic int res_width(input int img_width, input int ker_width);
        return img_width + ker_width + 1;
    endfunction

endpackage

// File: rtl/group_collect_if.sv
// Result-group input and serialised sample output bundle for group_collect.
interface group_collect_if #(
    parameter int GROUP_NB    = 4,
    parameter int IMG_WIDTH   = 16,
    parameter int KER_WIDTH   = 16,
    parameter int SHIFT_WIDTH = 6
);
    import group_collect_pkg::*;

    localparam int RES_WIDTH = res_width(IMG_WIDTH, KER_WIDTH);

    logic [GROUP_NB*RES_WIDTH-1:0] result;
    logic                          done;
    logic [SHIFT_WIDTH-1:0]        shift;
    logic [IMG_WIDTH-1:0]          out_data;
    logic                          out_val;
    logic                          out_rdy;
    logic                          out_last;
    logic                          busy;
    logic                          overflow;

    modport slave (
        input  result, done, shift, out_rdy,
        output out_data, out_val, out_last, busy, overflow
    );

    modport master (
        output result, done, shift, out_rdy,
        input  out_data, out_val, out_last, busy, overflow
    );

endinterface

// File: rtl/group_collect_requant_lane.sv
// requant_lane: round, arithmetic right shift and saturate one MAC accumulator.
// Optional negative clamp when GROUP_COLLECT_RELU_EN is defined.
module requant_lane
    import group_collect_pkg::*;
#(
    parameter int IMG_WIDTH   = 16,
    parameter int KER_WIDTH   = 16,
    parameter int SHIFT_WIDTH = 6
) (
    input  logic signed [res_width(IMG_WIDTH, KER_WIDTH)-1:0] i_acc,
    input  logic        [SHIFT_WIDTH-1:0]                     i_shift,
    output logic signed [IMG_WIDTH-1:0]                       o_data
);
    localparam int RES_WIDTH = res_width(IMG_WIDTH, KER_WIDTH);

    // One extra bit so adding the rounding constant can never wrap.
    localparam logic signed [RES_WIDTH:0] SAT_MAX =
        {{(RES_WIDTH+2-IMG_WIDTH){1'b0}}, {(IMG_WIDTH-1){1'b1}}};
    localparam logic signed [RES_WIDTH:0] SAT_MIN =
        {{(RES_WIDTH+2-IMG_WIDTH){1'b1}}, {(IMG_WIDTH-1){1'b0}}};

    logic signed [RES_WIDTH:0]   w_ext;
    logic signed [RES_WIDTH:0]   w_round;
    logic signed [RES_WIDTH:0]   w_sum;
    logic signed [RES_WIDTH:0]   w_shifted;
    logic signed [RES_WIDTH:0]   w_sat;
    logic                        w_big;

    always_comb begin
        w_ext     = {i_acc[RES_WIDTH-1], i_acc};
        w_big     = (32'(i_shift) >= 32'(RES_WIDTH));
        w_round   = '0;
        if (i_shift != '0 && !w_big) begin
            w_round = {{RES_WIDTH{1'b0}}, 1'b1} << (i_shift - SHIFT_WIDTH'(1));
        end
        w_sum     = w_ext + w_round;
        w_shifted = w_sum >>> i_shift;
        if (w_big) begin
            w_sat = '0;
        end else if (w_shifted > SAT_MAX) begin
            w_sat = SAT_MAX;
        end else if (w_shifted < SAT_MIN) begin
            w_sat = SAT_MIN;
        end else begin
            w_sat = w_shifted;
        end
`ifdef GROUP_COLLECT_RELU_EN
        if (w_sat[RES_WIDTH]) begin
            w_sat = '0;
        end
`endif
        o_data = w_sat[IMG_WIDTH-1:0];
    end

endmodule

// File: rtl/group_collect.sv
// group_collect: buffers one requantised MAC result group and drains it lane by lane.
// Define GROUP_COLLECT_RELU_EN to clamp negative samples to zero.
module group_collect
    import group_collect_pkg::*;
#(
    parameter int GROUP_NB    = 4,
    parameter int IMG_WIDTH   = 16,
    parameter int KER_WIDTH   = 16,
    parameter int SHIFT_WIDTH = 6
) (
    input logic           clk,
    input logic           rst,
    group_collect_if.slave bus
);
    localparam int RES_WIDTH = res_width(IMG_WIDTH, KER_WIDTH);
    localparam int IDX_W     = (GROUP_NB > 1) ? $clog2(GROUP_NB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(GROUP_NB - 1);

    logic [IMG_WIDTH-1:0] w_lane [GROUP_NB];

    for (genvar gi = 0; gi < GROUP_NB; gi++) begin : g_lane
        requant_lane #(
            .IMG_WIDTH  (IMG_WIDTH),
            .KER_WIDTH  (KER_WIDTH),
            .SHIFT_WIDTH(SHIFT_WIDTH)
        ) u_lane (
            .i_acc  ($signed(bus.result[gi*RES_WIDTH +: RES_WIDTH])),
            .i_shift(bus.shift),
            .o_data (w_lane[gi])
        );
    end

    state_t               r_state;
    logic [IDX_W-1:0]     r_idx;
    logic [IMG_WIDTH-1:0] r_buf [GROUP_NB];
    logic [IMG_WIDTH-1:0] r_out_data;
    logic                 r_last;
    logic                 r_overflow;

    logic w_xfer;
    logic w_final;
    logic w_capture;

    always_comb begin
        w_xfer    = (r_state == DRAIN) && bus.out_rdy;
        w_final   = w_xfer && r_last;
        w_capture = bus.done && ((r_state == IDLE) || w_final);
    end

    // out_data is registered alongside the index so it only changes at an accepted transfer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_idx      <= '0;
            r_out_data <= '0;
            r_last     <= 1'b0;
            r_overflow <= 1'b0;
            for (int unsigned i = 0; i < GROUP_NB; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            if (bus.done && (r_state == DRAIN) && !w_final) begin
                r_overflow <= 1'b1;
            end
            if (w_capture) begin
                for (int unsigned i = 0; i < GROUP_NB; i++) begin
                    r_buf[i] <= w_lane[i];
                end
                r_state    <= DRAIN;
                r_idx      <= '0;
                r_out_data <= w_lane[0];
                r_last     <= (GROUP_NB == 1);
            end else if (w_final) begin
                r_state <= IDLE;
                r_idx   <= '0;
                r_last  <= 1'b0;
            end else if (w_xfer) begin
                r_idx      <= r_idx + IDX_W'(1);
                r_out_data <= r_buf[r_idx + IDX_W'(1)];
                r_last     <= ((r_idx + IDX_W'(1)) == LAST_IDX);
            end
        end
    end

    assign bus.out_data = r_out_data;
    assign bus.out_val  = (r_state == DRAIN);
    assign bus.busy     = (r_state == DRAIN);
    assign bus.out_last = r_last;
    assign bus.overflow = r_overflow;

endmodule

// File: tb/tb_group_collect.sv
// Directed self-checking bench for group_collect (GROUP_NB=4, IMG_WIDTH=16, KER_WIDTH=16).
module tb_group_collect;

    localparam int GROUP_NB    = 4;
    localparam int IMG_WIDTH   = 16;
    localparam int KER_WIDTH   = 16;
    localparam int SHIFT_WIDTH = 6;
    localparam int RESW        = IMG_WIDTH + KER_WIDTH + 1;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    group_collect_if #(
        .GROUP_NB   (GROUP_NB),
        .IMG_WIDTH  (IMG_WIDTH),
        .KER_WIDTH  (KER_WIDTH),
        .SHIFT_WIDTH(SHIFT_WIDTH)
    ) bus ();

    group_collect #(
        .GROUP_NB   (GROUP_NB),
        .IMG_WIDTH  (IMG_WIDTH),
        .KER_WIDTH  (KER_WIDTH),
        .SHIFT_WIDTH(SHIFT_WIDTH)
    ) dut (
        .clk(clk),
        .rst(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int data_s();
        logic signed [IMG_WIDTH-1:0] d;
        d = bus.out_data;
        return int'(d);
    endfunction

    task automatic set_lanes(input int a, input int b, input int c, input int d);
        logic signed [RESW-1:0] t;
        t = a; bus.result[0*RESW +: RESW] = t;
        t = b; bus.result[1*RESW +: RESW] = t;
        t = c; bus.result[2*RESW +: RESW] = t;
        t = d; bus.result[3*RESW +: RESW] = t;
    endtask

    // Called at a negedge: raises done for one rising edge, returns at the following negedge.
    task automatic pulse(input int a, input int b, input int c, input int d, input int sh);
        set_lanes(a, b, c, d);
        bus.shift = SHIFT_WIDTH'(sh);
        bus.done  = 1'b1;
        @(negedge clk);
        bus.done  = 1'b0;
    endtask

    // Expects lane 0 already presented; checks all four lanes then the idle cycle.
    task automatic drain4(input string tag, input int e0, input int e1, input int e2, input int e3);
        int e [4];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("%s_val%0d", tag, k), int'(bus.out_val), 1);
            chk($sformatf("%s_data%0d", tag, k), data_s(), e[k]);
            chk($sformatf("%s_last%0d", tag, k), int'(bus.out_last), (k == 3) ? 1 : 0);
            @(negedge clk);
        end
        chk($sformatf("%s_idle_val", tag), int'(bus.out_val), 0);
        chk($sformatf("%s_idle_busy", tag), int'(bus.busy), 0);
    endtask

    initial begin
        int r0, r1, r2, r3;
        checks      = 0;
        errors      = 0;
        rst_n       = 1'b0;
        bus.result  = '0;
        bus.done    = 1'b0;
        bus.shift   = '0;
        bus.out_rdy = 1'b1;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_val", int'(bus.out_val), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_last", int'(bus.out_last), 0);
        chk("rst_ovf", int'(bus.overflow), 0);
        chk("rst_data", data_s(), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // saturation, shift 0
        pulse(100, -100, 70000, -70000, 0);
        drain4("sat", 100, -100, 32767, -32768);

        // rounding, shift 4
        pulse(24, -24, 23, -8, 4);
        drain4("rnd", 2, -1, 1, 0);

        // shift >= RES_WIDTH gives zero
        pulse(5000000, -5000000, -1, 1, 40);
        drain4("big", 0, 0, 0, 0);
        pulse(-70000, 70000, -3, 3, RESW);
        drain4("bigeq", 0, 0, 0, 0);

        // backpressure while index 1 is shown
        pulse(1, 2, 3, 4, 0);
        chk("bp_d0", data_s(), 1);
        @(negedge clk);
        chk("bp_d1", data_s(), 2);
        bus.out_rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("bp_hold_data%0d", k), data_s(), 2);
            chk($sformatf("bp_hold_val%0d", k), int'(bus.out_val), 1);
            chk($sformatf("bp_hold_last%0d", k), int'(bus.out_last), 0);
        end
        bus.out_rdy = 1'b1;
        @(negedge clk);
        chk("bp_d2", data_s(), 3);
        @(negedge clk);
        chk("bp_d3", data_s(), 4);
        chk("bp_last", int'(bus.out_last), 1);
        @(negedge clk);
        chk("bp_idle", int'(bus.out_val), 0);

        // overflow mid-drain, then back-to-back capture on the final transfer
        pulse(10, 20, 30, 40, 0);
        chk("ov_d0", data_s(), 10);
        @(negedge clk);
        chk("ov_d1", data_s(), 20);
        @(negedge clk);
        chk("ov_d2", data_s(), 30);
        chk("ov_pre", int'(bus.overflow), 0);
        pulse(50, 60, 70, 80, 0);
        chk("ov_flag", int'(bus.overflow), 1);
        chk("ov_d3", data_s(), 40);
        chk("ov_last", int'(bus.out_last), 1);
        pulse(5, 6, 7, 8, 0);
        drain4("b2b", 5, 6, 7, 8);
        chk("ov_sticky", int'(bus.overflow), 1);

        // asynchronous reset mid-drain
        pulse(1, 2, 3, 4, 0);
        chk("ar_d0", data_s(), 1);
        @(negedge clk);
        chk("ar_d1", data_s(), 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_val", int'(bus.out_val), 0);
        chk("ar_busy", int'(bus.busy), 0);
        chk("ar_ovf", int'(bus.overflow), 0);
        chk("ar_last", int'(bus.out_last), 0);
        chk("ar_data", data_s(), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pulse(11, 12, 13, 14, 0);
        drain4("post", 11, 12, 13, 14);

        // negative handling with and without the clamp
`ifdef GROUP_COLLECT_RELU_EN
        r0 = 0; r1 = 50; r2 = 0; r3 = 0;
`else
        r0 = -100; r1 = 50; r2 = -1; r3 = 0;
`endif
        pulse(-100, 50, -1, 0, 0);
        drain4("relu", r0, r1, r2, r3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/group_collect.md
GROUP_COLLECT -- requirements
Module: group_collect

Interface
REQ-001 SHALL have parameter GROUP_NB, default 4: number of MAC lanes in one result group.
REQ-002 SHALL have parameter IMG_WIDTH, default 16: signed output sample width.
REQ-003 SHALL have parameter KER_WIDTH, default 16: kernel width; lane width RES_WIDTH = IMG_WIDTH+KER_WIDTH+1.
REQ-004 SHALL have parameter SHIFT_WIDTH, default 6: width of the shift port.
REQ-005 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port result, input, GROUP_NB*RES_WIDTH: packed signed MAC accumulators, lane i at [i*RES_WIDTH +: RES_WIDTH].
REQ-008 SHALL have port done, input, 1: single-cycle pulse; result holds a completed group this cycle.
REQ-009 SHALL have port shift, input, SHIFT_WIDTH: right-shift amount, sampled with done.
REQ-010 SHALL have port out_data, output, IMG_WIDTH: requantised sample.
REQ-011 SHALL have port out_val, output, 1: out_data valid.
REQ-012 SHALL have port out_rdy, input, 1: downstream accepts.
REQ-013 SHALL have port out_last, output, 1: marks lane GROUP_NB-1.
REQ-014 SHALL have port busy, output, 1: high while a group is buffered.
REQ-015 SHALL have port overflow, output, 1: sticky error, a group was dropped.

Function
REQ-016 SHALL implement two states, IDLE and DRAIN, with a lane index 0..GROUP_NB-1.
REQ-017 SHALL, on done in IDLE, capture all lanes (already requantised) into a buffer at that edge and enter DRAIN with index 0.
REQ-018 SHALL set out_val = (state==DRAIN) and busy = out_val, giving out_val high on the cycle after done (latency 1).
REQ-019 SHALL drive out_data = buffer[index] and out_last = (index==GROUP_NB-1) in DRAIN.
REQ-020 SHALL advance the index only on out_val && out_rdy; out_data/out_last stay stable while out_rdy is low.
REQ-021 SHALL return to IDLE after the transfer with out_last high.
REQ-022 SHALL, when done coincides with the final transfer, capture the new group and stay in DRAIN at index 0 with no bubble cycle.
REQ-023 SHALL, on done in DRAIN otherwise, ignore the new group, leave buffer and index unchanged, and set overflow.
REQ-024 SHALL requantise each lane as: if shift>0 add 2^(shift-1); arithmetic right shift by shift; saturate to [-2^(IMG_WIDTH-1), 2^(IMG_WIDTH-1)-1].
REQ-025 SHALL perform rounding addition at RES_WIDTH+1 bits so the addition itself never wraps.
REQ-026 SHALL treat shift >= RES_WIDTH as a result of 0 (positive and negative inputs after rounding, i.e. sign-extension then saturation).

Reset
REQ-027 SHALL, while rst is low, force state IDLE, index 0, out_val 0, out_last 0, busy 0, overflow 0, out_data 0, independent of clk.
REQ-028 SHALL discard any buffered group when reset asserts mid-drain; overflow clears only on reset.

Configuration
REQ-029 SHALL, with GROUP_COLLECT_RELU_EN defined, clamp negative post-saturation values to 0 before buffering.
REQ-030 SHALL, without GROUP_COLLECT_RELU_EN, pass signed saturated values unchanged; no other behaviour differs.

Structure
REQ-031 SHALL take the RES_WIDTH derivation and the IDLE/DRAIN state encodings from the shared project package/header.
REQ-032 SHALL place round/shift/saturate (and the ReLU option) in one combinational sub-module, requant_lane, instantiated GROUP_NB times.

Verification (GROUP_NB=4, IMG_WIDTH=16, KER_WIDTH=16)
REQ-033 SHALL test: lanes {100,-100,70000,-70000}, shift 0, out_rdy=1, done at N -> out_data 100,-100,32767,-32768 at N+1..N+4, out_last only at N+4, busy low at N+5.
REQ-034 SHALL test: shift 4, lanes {24,-24,23,-8} -> 2,-1,1,0.
REQ-035 SHALL test: out_rdy low 3 cycles while index 1 shown -> out_data and out_val held for those cycles, sequence resumes unchanged.
REQ-036 SHALL test: done at index 2 -> overflow=1, remaining lanes from first group; done on final transfer -> new lane 0 on next cycle, no bubble.
REQ-037 SHALL test: rst low mid-drain, asynchronously between edges -> out_val, busy, overflow 0 immediately; next done starts at lane 0.
REQ-038 SHALL test: with GROUP_COLLECT_RELU_EN, lanes {-100,50,-1,0} -> 0,50,0,0; without it -> -100,50,-1,0.
